// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths and helpers for the register file slice
//
// Purpose: single home for register/ROB index widths used by reg_file and
// its operand resolver. Nothing here is redefined in the importing files.
//   REG_BIT  : architectural register id width
//   REG_NUM  : number of architectural registers
//   ROB_BIT  : ROB index width (rename tag width)
//   ROB_SIZE : ROB depth
//   XLEN     : data width
package reg_file_pkg;

  localparam int REG_BIT  = 5;
  localparam int REG_NUM  = 1 << REG_BIT;
  localparam int ROB_BIT  = 3;
  localparam int ROB_SIZE = 1 << ROB_BIT;
  localparam int XLEN     = 32;

  typedef logic [REG_BIT-1:0] reg_id_t;
  typedef logic [ROB_BIT-1:0] rob_tag_t;
  typedef logic [XLEN-1:0]    xdata_t;

  // x0 is hardwired to zero: it is never written and never renamed.
  function automatic logic is_writable(input reg_id_t id);
    return id != '0;
  endfunction

endpackage

// File: rtl/reg_operand_resolve.sv
// rtl/reg_operand_resolve.sv - resolves one decoder operand against rename state
//
// Purpose: turns one architectural source register into ready/value/tag,
// forwarding from the committing ROB head or the ROB lookup when renamed.
// Ports:
//   rs_id            in  source register id
//   busy, tag        in  rename state of rs_id
//   reg_value        in  architectural value of rs_id
//   rob_commit       in  ROB head commits this cycle
//   commit_rd_reg_id in  committed destination register
//   commit_rob_entry in  committed ROB slot
//   commit_value     in  committed data
//   rob_ready        in  ROB lookup of tag: result available
//   rob_value        in  ROB lookup of tag: result
//   ready            out operand available now
//   value            out operand value (zero when not ready)
//   rob_entry        out producer tag (meaningful when not ready)
module reg_operand_resolve
  import reg_file_pkg::*;
(
  input  logic     [REG_BIT-1:0] rs_id,
  input  logic                   busy,
  input  logic     [ROB_BIT-1:0] tag,
  input  logic     [XLEN-1:0]    reg_value,
  input  logic                   rob_commit,
  input  logic     [REG_BIT-1:0] commit_rd_reg_id,
  input  logic     [ROB_BIT-1:0] commit_rob_entry,
  input  logic     [XLEN-1:0]    commit_value,
  input  logic                   rob_ready,
  input  logic     [XLEN-1:0]    rob_value,
  output logic                   ready,
  output logic     [XLEN-1:0]    value,
  output logic     [ROB_BIT-1:0] rob_entry
);

  // The producer is committing right now: its tag must match, otherwise an
  // older instance of rd is retiring while a younger rename is still live.
  logic commit_hit;
  assign commit_hit = rob_commit && (commit_rd_reg_id == rs_id) &&
                      (commit_rob_entry == tag);

  always_comb begin
    ready     = 1'b1;
    value     = '0;
    rob_entry = '0;
    if (rs_id == '0) begin
      ready = 1'b1;
    end else if (busy && commit_hit) begin
      value     = commit_value;
      rob_entry = tag;
    end else if (busy && rob_ready) begin
      value     = rob_value;
      rob_entry = tag;
    end else if (busy) begin
      ready     = 1'b0;
      rob_entry = tag;
    end else begin
      value = reg_value;
    end
  end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with ROB rename tags
//
// Purpose: holds committed register values plus a busy bit and producer tag
// per register. Issue renames rd to a ROB slot, commit writes the value and
// releases the rename if the tag still matches, clear_up drops all renames.
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (freeze state when low)
//   clear_up                                  mispredict flush
//   issue_pollute/issue_reg_id/issue_rob_entry rename request
//   rob_commit/commit_rd_reg_id/commit_rob_entry/commit_value  retire
//   rs1_id/rs2_id                             decoder operand queries
//   rs1_/rs2_ ready/value/rob_entry           resolved operands
//   get_rob_entry1/2                          tags sent to ROB lookup
//   ready1/ready2, value1/value2              ROB lookup results
module reg_file
  import reg_file_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear_up,
  input  logic               issue_pollute,
  input  logic [REG_BIT-1:0] issue_reg_id,
  input  logic [ROB_BIT-1:0] issue_rob_entry,
  input  logic               rob_commit,
  input  logic [REG_BIT-1:0] commit_rd_reg_id,
  input  logic [ROB_BIT-1:0] commit_rob_entry,
  input  logic [XLEN-1:0]    commit_value,
  input  logic [REG_BIT-1:0] rs1_id,
  input  logic [REG_BIT-1:0] rs2_id,
  output logic               rs1_ready,
  output logic               rs2_ready,
  output logic [XLEN-1:0]    rs1_value,
  output logic [XLEN-1:0]    rs2_value,
  output logic [ROB_BIT-1:0] rs1_rob_entry,
  output logic [ROB_BIT-1:0] rs2_rob_entry,
  output logic [ROB_BIT-1:0] get_rob_entry1,
  output logic [ROB_BIT-1:0] get_rob_entry2,
  input  logic               ready1,
  input  logic               ready2,
  input  logic [XLEN-1:0]    value1,
  input  logic [XLEN-1:0]    value2
);

  logic [XLEN-1:0]    regs [REG_NUM];
  logic [ROB_BIT-1:0] tag  [REG_NUM];
  logic [REG_NUM-1:0] busy;

  logic commit_wr;
  logic issue_wr;
  assign commit_wr = rob_commit && is_writable(commit_rd_reg_id);
  assign issue_wr  = issue_pollute && is_writable(issue_reg_id) && !clear_up;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
        tag[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (commit_wr) begin
        regs[commit_rd_reg_id] <= commit_value;
        // Only the newest rename may release busy; an older producer
        // retiring leaves the younger rename pending.
        if (tag[commit_rd_reg_id] == commit_rob_entry) begin
          busy[commit_rd_reg_id] <= 1'b0;
        end
      end
      // Later assignments win, so a same-cycle issue to the committed rd
      // keeps it busy under the new tag.
      if (clear_up) begin
        busy <= '0;
        for (int i = 0; i < REG_NUM; i++) begin
          tag[i] <= '0;
        end
      end else if (issue_wr) begin
        busy[issue_reg_id] <= 1'b1;
        tag[issue_reg_id]  <= issue_rob_entry;
      end
    end
  end

  // Operands see pre-issue state: this cycle's rename only lands at the edge.
  assign get_rob_entry1 = tag[rs1_id];
  assign get_rob_entry2 = tag[rs2_id];

  reg_operand_resolve u_rs1 (
    .rs_id            (rs1_id),
    .busy             (busy[rs1_id]),
    .tag              (tag[rs1_id]),
    .reg_value        (regs[rs1_id]),
    .rob_commit       (rob_commit),
    .commit_rd_reg_id (commit_rd_reg_id),
    .commit_rob_entry (commit_rob_entry),
    .commit_value     (commit_value),
    .rob_ready        (ready1),
    .rob_value        (value1),
    .ready            (rs1_ready),
    .value            (rs1_value),
    .rob_entry        (rs1_rob_entry)
  );

  reg_operand_resolve u_rs2 (
    .rs_id            (rs2_id),
    .busy             (busy[rs2_id]),
    .tag              (tag[rs2_id]),
    .reg_value        (regs[rs2_id]),
    .rob_commit       (rob_commit),
    .commit_rd_reg_id (commit_rd_reg_id),
    .commit_rob_entry (commit_rob_entry),
    .commit_value     (commit_value),
    .rob_ready        (ready2),
    .rob_value        (value2),
    .ready            (rs2_ready),
    .value            (rs2_value),
    .rob_entry        (rs2_rob_entry)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file
module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_up;
  logic        issue_pollute;
  logic [4:0]  issue_reg_id;
  logic [2:0]  issue_rob_entry;
  logic        rob_commit;
  logic [4:0]  commit_rd_reg_id;
  logic [2:0]  commit_rob_entry;
  logic [31:0] commit_value;
  logic [4:0]  rs1_id, rs2_id;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_value, rs2_value;
  logic [2:0]  rs1_rob_entry, rs2_rob_entry;
  logic [2:0]  get_rob_entry1, get_rob_entry2;
  logic        ready1, ready2;
  logic [31:0] value1, value2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: plain arrays updated from the retire/rename rules.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [2:0]  m_tag  [32];

  always #5 clk_in = ~clk_in;

  reg_file dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .clear_up         (clear_up),
    .issue_pollute    (issue_pollute),
    .issue_reg_id     (issue_reg_id),
    .issue_rob_entry  (issue_rob_entry),
    .rob_commit       (rob_commit),
    .commit_rd_reg_id (commit_rd_reg_id),
    .commit_rob_entry (commit_rob_entry),
    .commit_value     (commit_value),
    .rs1_id           (rs1_id),
    .rs2_id           (rs2_id),
    .rs1_ready        (rs1_ready),
    .rs2_ready        (rs2_ready),
    .rs1_value        (rs1_value),
    .rs2_value        (rs2_value),
    .rs1_rob_entry    (rs1_rob_entry),
    .rs2_rob_entry    (rs2_rob_entry),
    .get_rob_entry1   (get_rob_entry1),
    .get_rob_entry2   (get_rob_entry2),
    .ready1           (ready1),
    .ready2           (ready2),
    .value1           (value1),
    .value2           (value2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  task automatic idle();
    rdy_in = 1'b1; clear_up = 1'b0; issue_pollute = 1'b0; issue_reg_id = '0;
    issue_rob_entry = '0; rob_commit = 1'b0; commit_rd_reg_id = '0;
    commit_rob_entry = '0; commit_value = '0; ready1 = 1'b0; ready2 = 1'b0;
    value1 = '0; value2 = '0;
  endtask

  // Expected operand: zero reg, then committing producer, then ROB lookup,
  // then pending, else the architectural value.
  task automatic check_operand(input string name, input logic [4:0] id,
                               input logic rdy, input logic [31:0] lval,
                               input logic got_ready, input logic [31:0] got_value,
                               input logic [2:0] got_entry, input logic [2:0] got_lookup);
    logic        e_ready;
    logic [31:0] e_value;
    logic [2:0]  e_entry;
    bit          entry_defined;
    entry_defined = 1'b1;
    e_entry = 3'd0;
    if (id == 5'd0) begin
      e_ready = 1'b1; e_value = 32'd0;
    end else if (m_busy[id] && rob_commit && commit_rd_reg_id == id && commit_rob_entry == m_tag[id]) begin
      e_ready = 1'b1; e_value = commit_value; entry_defined = 1'b0;
    end else if (m_busy[id] && rdy) begin
      e_ready = 1'b1; e_value = lval; entry_defined = 1'b0;
    end else if (m_busy[id]) begin
      e_ready = 1'b0; e_value = 32'd0; e_entry = m_tag[id];
    end else begin
      e_ready = 1'b1; e_value = m_regs[id];
    end
    check({name, "_ready"}, {31'd0, got_ready}, {31'd0, e_ready});
    check({name, "_value"}, got_value, e_value);
    check({name, "_lookup"}, {29'd0, got_lookup}, {29'd0, m_tag[id]});
    if (entry_defined) check({name, "_entry"}, {29'd0, got_entry}, {29'd0, e_entry});
  endtask

  task automatic check_outputs();
    check_operand("rs1", rs1_id, ready1, value1, rs1_ready, rs1_value, rs1_rob_entry, get_rob_entry1);
    check_operand("rs2", rs2_id, ready2, value2, rs2_ready, rs2_value, rs2_rob_entry, get_rob_entry2);
  endtask

  task automatic model_edge();
    if (rst_in && rdy_in) begin
      if (rob_commit && commit_rd_reg_id != 5'd0) begin
        m_regs[commit_rd_reg_id] = commit_value;
        if (m_tag[commit_rd_reg_id] == commit_rob_entry) m_busy[commit_rd_reg_id] = 1'b0;
      end
      if (clear_up) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 1'b0;
          m_tag[i]  = '0;
        end
      end else if (issue_pollute && issue_reg_id != 5'd0) begin
        m_busy[issue_reg_id] = 1'b1;
        m_tag[issue_reg_id]  = issue_rob_entry;
      end
    end
  endtask

  // Inputs are set while clk is low; check, take the edge, return at negedge.
  task automatic run_cycle();
    #1;
    check_outputs();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
  endtask

  initial begin
    idle();
    rs1_id = 5'd5; rs2_id = 5'd0;
    rst_in = 1'b0;
    model_reset();
    #2;
    // T1: reset state
    check("t1_rst_ready1", {31'd0, rs1_ready}, 32'd1);
    check("t1_rst_value1", rs1_value, 32'd0);
    check("t1_rst_ready2", {31'd0, rs2_ready}, 32'd1);
    @(negedge clk_in);
    rst_in = 1'b1;
    run_cycle();
    rob_commit = 1'b1; commit_rd_reg_id = 5'd0; commit_value = 32'hDEAD;
    run_cycle();
    idle();
    rs1_id = 5'd0;
    #1 check("t1_x0_value", rs1_value, 32'd0);
    run_cycle();

    // T2: issue x3 -> entry 2, then ROB lookup forwarding
    issue_pollute = 1'b1; issue_reg_id = 5'd3; issue_rob_entry = 3'd2; rs1_id = 5'd3;
    #1 check("t2_pre_issue_ready", {31'd0, rs1_ready}, 32'd1);
    run_cycle();
    idle(); rs1_id = 5'd3;
    #1 check("t2_pending_ready", {31'd0, rs1_ready}, 32'd0);
    check("t2_pending_entry", {29'd0, rs1_rob_entry}, 32'd2);
    run_cycle();
    ready1 = 1'b1; value1 = 32'h55;
    #1 check("t2_lookup_value", rs1_value, 32'h55);
    run_cycle();

    // T3: commit bypass same cycle, then architectural value
    idle(); rs1_id = 5'd3;
    rob_commit = 1'b1; commit_rd_reg_id = 5'd3; commit_rob_entry = 3'd2; commit_value = 32'h77;
    #1 check("t3_bypass_value", rs1_value, 32'h77);
    run_cycle();
    idle(); rs1_id = 5'd3;
    #1 check("t3_reg_value", rs1_value, 32'h77);
    check("t3_reg_ready", {31'd0, rs1_ready}, 32'd1);
    run_cycle();

    // T4: older producer retires while a younger rename is live
    issue_pollute = 1'b1; issue_reg_id = 5'd4; issue_rob_entry = 3'd1;
    run_cycle();
    issue_rob_entry = 3'd5;
    run_cycle();
    idle(); rob_commit = 1'b1; commit_rd_reg_id = 5'd4; commit_rob_entry = 3'd1; commit_value = 32'd9;
    rs1_id = 5'd4;
    run_cycle();
    idle(); rs1_id = 5'd4;
    #1 check("t4_still_busy", {31'd0, rs1_ready}, 32'd0);
    check("t4_young_entry", {29'd0, rs1_rob_entry}, 32'd5);
    run_cycle();

    // T5: flush with a dropped issue, then a frozen cycle
    issue_pollute = 1'b1; issue_reg_id = 5'd6; issue_rob_entry = 3'd3;
    run_cycle();
    issue_reg_id = 5'd7; issue_rob_entry = 3'd4;
    run_cycle();
    idle(); clear_up = 1'b1; issue_pollute = 1'b1; issue_reg_id = 5'd8; issue_rob_entry = 3'd6;
    rs1_id = 5'd6; rs2_id = 5'd7;
    run_cycle();
    idle(); rs1_id = 5'd6; rs2_id = 5'd8;
    #1 check("t5_x6_ready", {31'd0, rs1_ready}, 32'd1);
    check("t5_x8_ready", {31'd0, rs2_ready}, 32'd1);
    run_cycle();
    rdy_in = 1'b0; issue_pollute = 1'b1; issue_reg_id = 5'd9; issue_rob_entry = 3'd1;
    rob_commit = 1'b1; commit_rd_reg_id = 5'd10; commit_rob_entry = 3'd0; commit_value = 32'hBEEF;
    run_cycle();
    idle(); rs1_id = 5'd9; rs2_id = 5'd10;
    #1 check("t5_frozen_busy", {31'd0, rs1_ready}, 32'd1);
    check("t5_frozen_reg", rs2_value, 32'd0);
    run_cycle();

    // Random traffic on a small register window to force aliasing.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] cr;
      rdy_in          = ($urandom_range(0, 9) != 0);
      clear_up        = ($urandom_range(0, 24) == 0);
      issue_pollute   = $urandom_range(0, 1);
      issue_reg_id    = 5'($urandom_range(0, 7));
      issue_rob_entry = 3'($urandom);
      cr              = 5'($urandom_range(0, 7));
      rob_commit      = ($urandom_range(0, 9) < 4);
      commit_rd_reg_id = cr;
      commit_rob_entry = ($urandom_range(0, 2) != 0) ? m_tag[cr] : 3'($urandom);
      commit_value    = $urandom;
      rs1_id          = ($urandom_range(0, 3) == 0) ? cr : 5'($urandom_range(0, 7));
      rs2_id          = 5'($urandom_range(0, 7));
      ready1          = ($urandom_range(0, 2) == 0);
      ready2          = ($urandom_range(0, 2) == 0);
      value1          = $urandom;
      value2          = $urandom;
      run_cycle();
    end

    // T6: asynchronous reset while registers are renamed
    idle();
    issue_pollute = 1'b1; issue_reg_id = 5'd12; issue_rob_entry = 3'd3;
    run_cycle();
    idle();
    rob_commit = 1'b1; commit_rd_reg_id = 5'd13; commit_rob_entry = 3'd0; commit_value = 32'h1234;
    run_cycle();
    idle(); rs1_id = 5'd12; rs2_id = 5'd13;
    #1 check("t6_pre_busy", {31'd0, rs1_ready}, 32'd0);
    #1 rst_in = 1'b0;
    model_reset();
    #1;
    check("t6_rst_ready1", {31'd0, rs1_ready}, 32'd1);
    check("t6_rst_value1", rs1_value, 32'd0);
    check("t6_rst_value2", rs2_value, 32'd0);
    check_outputs();
    @(negedge clk_in);
    rst_in = 1'b1;
    run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
